notch_requant_fifo: RTL and testbench

- Downstream consumer of the second-order IIR notch filter.
- Takes the filter's signed Q16.16 output samples and applies first-order error-feedback requantization to an OUT_BITS unsigned offset-binary code.
- Saturates the code and buffers it in a small FIFO with a valid/ready handshake towards the DEM switch-block tree.

---
 rtl/lib_switchblock_pkg.sv | 10 +
 rtl/dem_code_fifo.sv | 59 +++++
 rtl/notch_requant_fifo.sv | 117 +++++++++++
 tb/tb_notch_requant_fifo.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/lib_switchblock_pkg.sv
// rtl/lib_switchblock_pkg.sv - shared word widths and types for the notch requantizer / DEM path
package lib_switchblock_pkg;
    localparam int WIDTH      = 16;
    localparam int FRAC_BITS  = 16;
    localparam int OUT_BITS   = 4;
    localparam int FIFO_DEPTH = 4;

    typedef logic signed [2*WIDTH-1:0] q16_16_t;
    typedef logic [OUT_BITS-1:0]       dem_code_t;
endpackage

// File: rtl/dem_code_fifo.sv
// rtl/dem_code_fifo.sv - synchronous FIFO of DEM codes with occupancy count
module dem_code_fifo
    import lib_switchblock_pkg::*;
#(
    parameter int DATA_W = OUT_BITS,
    parameter int DEPTH  = FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    // Head reads as zero while empty so the output is defined without resetting storage
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/notch_requant_fifo.sv
// rtl/notch_requant_fifo.sv - error-feedback requantizer to offset-binary DEM codes with output FIFO
// Optional saturation event counter enabled by NOTCH_REQUANT_SAT_CNT_EN.
module notch_requant_fifo #(
    parameter int WIDTH      = lib_switchblock_pkg::WIDTH,
    parameter int FRAC_BITS  = lib_switchblock_pkg::FRAC_BITS,
    parameter int OUT_BITS   = lib_switchblock_pkg::OUT_BITS,
    parameter int FIFO_DEPTH = lib_switchblock_pkg::FIFO_DEPTH
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [2*WIDTH-1:0]            y_in_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    output logic [OUT_BITS-1:0]           code_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          sat_o,
    output logic [15:0]                   sat_cnt_o
);
    import lib_switchblock_pkg::*;

    localparam int EW = 2*WIDTH;
    localparam int VW = EW + 1;
    localparam logic signed [VW-1:0] HALF     = VW'(2**(FRAC_BITS-1));
    localparam logic signed [VW-1:0] OFFSET   = VW'(2**(OUT_BITS-1));
    localparam logic signed [VW-1:0] CODE_MAX = VW'(2**OUT_BITS - 1);

    logic signed [EW-1:0] e_q;
    logic signed [EW-1:0] e_next;
    logic signed [VW-1:0] v_sum;
    logic signed [EW-1:0] v;
    logic signed [VW-1:0] v_round;
    logic signed [VW-1:0] q;
    logic signed [VW-1:0] c;
    logic [OUT_BITS-1:0]  code;
    logic                 sat;
    logic                 sat_q;
    logic                 accept;
    logic                 full;
    logic                 empty;

    assign accept = in_valid_i && in_ready_o;

    always_comb begin
        v_sum = {y_in_i[EW-1], y_in_i} + {e_q[EW-1], e_q};
        // Clip the one-bit-wider sum back into the signed sample range
        if (v_sum[VW-1] != v_sum[VW-2]) begin
            v = v_sum[VW-1] ? {1'b1, {(EW-1){1'b0}}} : {1'b0, {(EW-1){1'b1}}};
        end else begin
            v = v_sum[EW-1:0];
        end
        v_round = {v[EW-1], v} + HALF;
        q       = v_round >>> FRAC_BITS;
        c       = q + OFFSET;
        sat     = 1'b0;
        code    = c[OUT_BITS-1:0];
        if (c[VW-1]) begin
            code = '0;
            sat  = 1'b1;
        end else if (c > CODE_MAX) begin
            code = '1;
            sat  = 1'b1;
        end
        // Unsaturated code equals q + offset, so the residual is v - q*2^FRAC_BITS
        e_next = sat ? '0 : v - EW'(q <<< FRAC_BITS);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            e_q   <= '0;
            sat_q <= 1'b0;
        end else begin
            sat_q <= accept && sat;
            if (accept) begin
                e_q <= e_next;
            end
        end
    end

    assign sat_o = sat_q;

`ifdef NOTCH_REQUANT_SAT_CNT_EN
    logic [15:0] sat_cnt_q;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sat_cnt_q <= '0;
        end else if (accept && sat && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_q <= sat_cnt_q + 16'd1;
        end
    end

    assign sat_cnt_o = sat_cnt_q;
`else
    assign sat_cnt_o = '0;
`endif

    dem_code_fifo #(
        .DATA_W (OUT_BITS),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (reset_i),
        .push      (accept),
        .push_data (code),
        .pop       (out_ready_i),
        .pop_data  (code_o),
        .full      (full),
        .empty     (empty),
        .count     (count_o)
    );

    // Full deliberately blocks input even when the head is being popped this cycle
    assign in_ready_o  = !full;
    assign out_valid_o = !empty;
endmodule

// File: tb/tb_notch_requant_fifo.sv
// tb/tb_notch_requant_fifo.sv - directed table-driven bench for notch_requant_fifo
module tb_notch_requant_fifo;
    logic        clk;
    logic        rst_n;
    logic [31:0] y_in;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  code;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  count;
    logic        sat;
    logic [15:0] sat_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_sat_cnt = 0;

    typedef struct {
        logic [31:0] y;
        logic [3:0]  code;
        logic        sat;
        logic [31:0] e;
    } vec_t;

    vec_t vecs [11];

    notch_requant_fifo dut (
        .clk_i       (clk),
        .reset_i     (rst_n),
        .y_in_i      (y_in),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .code_o      (code),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .count_o     (count),
        .sat_o       (sat),
        .sat_cnt_o   (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] y);
        @(negedge clk);
        y_in     = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        y_in      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        vecs[0]  = '{32'h0002_0000, 4'd10, 1'b0, 32'h0000_0000};
        vecs[1]  = '{32'h0000_8000, 4'd9,  1'b0, 32'hFFFF_8000};
        vecs[2]  = '{32'h0000_8000, 4'd8,  1'b0, 32'h0000_0000};
        vecs[3]  = '{32'h0010_0000, 4'd15, 1'b1, 32'h0000_0000};
        vecs[4]  = '{32'hFFF7_0000, 4'd0,  1'b1, 32'h0000_0000};
        vecs[5]  = '{32'h0007_0000, 4'd15, 1'b0, 32'h0000_0000};
        vecs[6]  = '{32'hFFF8_0000, 4'd0,  1'b0, 32'h0000_0000};
        vecs[7]  = '{32'hFFFF_8000, 4'd8,  1'b0, 32'hFFFF_8000};
        vecs[8]  = '{32'h0000_4000, 4'd8,  1'b0, 32'hFFFF_C000};
        vecs[9]  = '{32'h8000_0000, 4'd0,  1'b1, 32'h0000_0000};
        vecs[10] = '{32'h7FFF_FFFF, 4'd15, 1'b1, 32'h0000_0000};

        #12;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_code", 32'(code), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
        chk("rst_e", dut.e_q, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 11; i++) begin
            push(vecs[i].y);
            chk($sformatf("v%0d_code", i), 32'(code), 32'(vecs[i].code));
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_sat", i), 32'(sat), 32'(vecs[i].sat));
            chk($sformatf("v%0d_e", i), dut.e_q, vecs[i].e);
`ifdef NOTCH_REQUANT_SAT_CNT_EN
            if (vecs[i].sat) exp_sat_cnt++;
`endif
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_drained", i), 32'(out_valid), 32'd0);
            chk($sformatf("v%0d_sat_drop", i), 32'(sat), 32'd0);
        end
        chk("sat_cnt", 32'(sat_cnt), 32'(exp_sat_cnt));

        // Backpressure: four fill the FIFO, the fifth waits
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) push(32'(k) << 16);
        chk("bp_count_full", 32'(count), 32'd4);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_head", 32'(code), 32'd9);
        @(negedge clk);
        y_in     = 32'h0005_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_held_count", 32'(count), 32'd4);
        chk("bp_head_stable", 32'(code), 32'd9);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_pop1_count", 32'(count), 32'd3);
        chk("bp_pop1_ready", 32'(in_ready), 32'd1);
        chk("bp_pop1_head", 32'(code), 32'd10);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_accept5_count", 32'(count), 32'd3);
        for (int k = 11; k <= 13; k++) begin
            chk($sformatf("bp_order_%0d", k), 32'(code), 32'(k));
            @(posedge clk);
            #1;
        end
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk("bp_count_zero", 32'(count), 32'd0);

        // Simultaneous push and pop at occupancy 2
        out_ready = 1'b0;
        push(32'h0001_0000);
        push(32'h0002_0000);
        chk("pp_count_before", 32'(count), 32'd2);
        @(negedge clk);
        y_in      = 32'h0003_0000;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("pp_count_same", 32'(count), 32'd2);
        chk("pp_head", 32'(code), 32'd10);
        @(posedge clk);
        #1;
        chk("pp_tail", 32'(code), 32'd11);
        @(posedge clk);
        #1;
        chk("pp_empty", 32'(count), 32'd0);

        // Asynchronous reset with data buffered and nonzero error
        out_ready = 1'b0;
        push(32'h0000_8000);
        push(32'h0001_0000);
        push(32'h0002_0000);
        chk("ar_count_before", 32'(count), 32'd3);
        chk("ar_e_before", dut.e_q, 32'hFFFF_8000);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_e", dut.e_q, 32'd0);
        chk("ar_code", 32'(code), 32'd0);
        chk("ar_sat_cnt", 32'(sat_cnt), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        push(32'h0000_8000);
        chk("ar_post_code", 32'(code), 32'd9);
        chk("ar_post_valid", 32'(out_valid), 32'd1);
        chk("ar_post_e", dut.e_q, 32'hFFFF_8000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
